// File: rtl/neuron_probe.sv
// Purpose : sweeps a 2-input threshold neuron through {x,y}=00,01,10,11, captures fire, decodes the function.
// Latency : start accepted at cycle T -> busy T+1..T+4*SETTLE_CYCLES, done pulse at T+1+4*SETTLE_CYCLES.
// Backpr. : none; start is honoured only in IDLE, ignored (not queued) in SWEEP/DONE.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, thresh_cfg   sweep request and threshold latched on acceptance
//   x, y, Threshold     drive the neuron under test; fire is its output
//   busy, done          sweep in progress / one-cycle results-valid pulse
//   truth, func_code    captured table (bit index {x,y}) and decoded function
//   error               table does not match any monotonic 2-input function
//   expect_code, pass   only with NEURON_PROBE_EXPECT_EN: expected code and match flag
module neuron_probe #(
    parameter int SETTLE_CYCLES = 2,
    parameter int THRESH_W      = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [THRESH_W-1:0] thresh_cfg,
    output logic                x,
    output logic                y,
    output logic [THRESH_W-1:0] Threshold,
    input  logic                fire,
    output logic                busy,
    output logic                done,
    output logic [3:0]          truth,
    output logic [2:0]          func_code,
    output logic                error
`ifdef NEURON_PROBE_EXPECT_EN
    ,
    input  logic [2:0]          expect_code,
    output logic                pass
`endif
);

    // A one-cycle settle still needs a 1-bit counter.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [THRESH_W-1:0] thr_q, thr_d;
    logic [3:0]          truth_q, truth_d;
    logic [2:0]          func_q, func_d;
    logic                err_q, err_d;
`ifdef NEURON_PROBE_EXPECT_EN
    logic [2:0]          exp_q, exp_d;
    logic                pass_q, pass_d;
`endif

    function automatic logic [2:0] decode(input logic [3:0] t);
        logic [2:0] c;
        case (t)
            4'b0000: c = 3'd0;
            4'b1000: c = 3'd1;
            4'b1100: c = 3'd2;
            4'b1010: c = 3'd3;
            4'b1110: c = 3'd4;
            4'b1111: c = 3'd5;
            default: c = 3'd7;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        thr_d   = thr_q;
        truth_d = truth_q;
        func_d  = func_q;
        err_d   = err_q;
`ifdef NEURON_PROBE_EXPECT_EN
        exp_d   = exp_q;
        pass_d  = pass_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    thr_d   = thresh_cfg;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    truth_d = 4'b0000;
                    state_d = ST_SWEEP;
`ifdef NEURON_PROBE_EXPECT_EN
                    exp_d   = expect_code;
`endif
                end
            end
            ST_SWEEP: begin
                if (cnt_q == CNT_LAST) begin
                    truth_d[idx_q] = fire;
                    idx_d          = idx_q + 2'd1;
                    cnt_d          = '0;
                    if (idx_q == 2'd3) begin
                        // Decode the completed table (including the bit written
                        // this edge) so results are already valid while done is high.
                        state_d = ST_DONE;
                        func_d  = decode(truth_d);
                        err_d   = (decode(truth_d) == 3'd7);
`ifdef NEURON_PROBE_EXPECT_EN
                        pass_d  = (decode(truth_d) == exp_q) && (decode(truth_d) != 3'd7);
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            thr_q   <= '0;
            truth_q <= 4'b0000;
            func_q  <= 3'd0;
            err_q   <= 1'b0;
`ifdef NEURON_PROBE_EXPECT_EN
            exp_q   <= 3'd0;
            pass_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            thr_q   <= thr_d;
            truth_q <= truth_d;
            func_q  <= func_d;
            err_q   <= err_d;
`ifdef NEURON_PROBE_EXPECT_EN
            exp_q   <= exp_d;
            pass_q  <= pass_d;
`endif
        end
    end

    // Neuron inputs are parked at 00 outside a sweep.
    assign x         = (state_q == ST_SWEEP) ? idx_q[1] : 1'b0;
    assign y         = (state_q == ST_SWEEP) ? idx_q[0] : 1'b0;
    assign Threshold = thr_q;
    assign busy      = (state_q == ST_SWEEP);
    assign done      = (state_q == ST_DONE);
    assign truth     = truth_q;
    assign func_code = func_q;
    assign error     = err_q;
`ifdef NEURON_PROBE_EXPECT_EN
    assign pass      = pass_q;
`endif

endmodule

// File: tb/tb_neuron_probe.sv
// Purpose : directed bench for neuron_probe driving a behavioural threshold neuron.
// Latency : expects done 9 cycles after an accepted start (SETTLE_CYCLES=2).
// Backpr. : n/a; start re-pulses during a sweep must be ignored.
module tb_neuron_probe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] thresh_cfg;
    logic       x, y;
    logic [1:0] Threshold;
    logic       fire;
    logic       busy, done;
    logic [3:0] truth;
    logic [2:0] func_code;
    logic       error;
    logic [2:0] expect_code;
    logic       use_xor;
`ifdef NEURON_PROBE_EXPECT_EN
    logic       pass;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural neuron: threshold unit, or XOR for the invalid-table case.
    always_comb begin
        if (use_xor) fire = x ^ y;
        else         fire = ((int'(x) + int'(y)) >= int'(Threshold));
    end

    neuron_probe #(.SETTLE_CYCLES(2), .THRESH_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .thresh_cfg (thresh_cfg),
        .x          (x),
        .y          (y),
        .Threshold  (Threshold),
        .fire       (fire),
        .busy       (busy),
        .done       (done),
        .truth      (truth),
        .func_code  (func_code),
        .error      (error)
`ifdef NEURON_PROBE_EXPECT_EN
        ,
        .expect_code(expect_code),
        .pass       (pass)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a start and returns in the done cycle (or after a bounded wait).
    task automatic run_sweep(input logic [1:0] th, input logic [2:0] ex, output int lat);
        thresh_cfg  = th;
        expect_code = ex;
        start       = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int dcnt;
        rst_n       = 1'b0;
        start       = 1'b0;
        thresh_cfg  = 2'd0;
        expect_code = 3'd0;
        use_xor     = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_thr", Threshold, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_truth", truth, 0);
        chk("rst_func", func_code, 0);
        chk("rst_err", error, 0);
`ifdef NEURON_PROBE_EXPECT_EN
        chk("rst_pass", pass, 0);
`endif
        rst_n = 1'b1;
        tick();

        // 1: AND, with cycle-exact x/y stepping and done at T+9
        thresh_cfg = 2'd2;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            chk("s1_xy", {x, y}, c / 2);
            chk("s1_busy", busy, 1);
            chk("s1_nodone", done, 0);
            tick();
        end
        chk("s1_done", done, 1);
        chk("s1_busy_off", busy, 0);
        chk("s1_truth", truth, 4'b1000);
        chk("s1_func", func_code, 1);
        chk("s1_err", error, 0);
        tick();
        chk("s1_done_pulse", done, 0);
        chk("s1_hold_func", func_code, 1);

        // 2: OR
        run_sweep(2'd1, 3'd0, lat);
        chk("s2_lat", lat, 9);
        chk("s2_truth", truth, 4'b1110);
        chk("s2_func", func_code, 4);
        tick();

        // 3: CONST1 then CONST0; func holds old value during next sweep
        run_sweep(2'd0, 3'd0, lat);
        chk("s3a_truth", truth, 4'b1111);
        chk("s3a_func", func_code, 5);
        tick();
        thresh_cfg = 2'd3;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk("s3_truth_clr", truth, 0);
        chk("s3_func_held", func_code, 5);
        chk("s3_thr", Threshold, 3);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        chk("s3b_lat", lat, 9);
        chk("s3b_truth", truth, 4'b0000);
        chk("s3b_func", func_code, 0);
        tick();
        tick();
        chk("s3_thr_idle", Threshold, 3);
        chk("s3_xy_idle", {x, y}, 0);

        // 4: start re-pulsed in SWEEP (with a new threshold) and in DONE
        thresh_cfg = 2'd2;
        start      = 1'b1;
        tick();
        dcnt = 0;
        for (int i = 1; i <= 20; i++) begin
            start = (i == 3) || (i == 9);
            if (i == 3) thresh_cfg = 2'd0;
            if (done === 1'b1) dcnt++;
            if (i == 10) chk("s4_no_restart", busy, 0);
            tick();
        end
        start = 1'b0;
        chk("s4_done_cnt", dcnt, 1);
        chk("s4_truth", truth, 4'b1000);
        chk("s4_func", func_code, 1);

        // 5: XOR -> invalid
        use_xor = 1'b1;
        run_sweep(2'd2, 3'd0, lat);
        chk("s5_lat", lat, 9);
        chk("s5_truth", truth, 4'b0110);
        chk("s5_func", func_code, 7);
        chk("s5_err", error, 1);
        tick();
        use_xor = 1'b0;

        // 6: reset mid-sweep at idx=2
        thresh_cfg = 2'd1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("s6_idx2", {x, y}, 2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("s6_x", x, 0);
        chk("s6_y", y, 0);
        chk("s6_thr", Threshold, 0);
        chk("s6_busy", busy, 0);
        chk("s6_done", done, 0);
        chk("s6_truth", truth, 0);
        chk("s6_func", func_code, 0);
        chk("s6_err", error, 0);
        dcnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (done === 1'b1) dcnt++;
            tick();
        end
        chk("s6_no_done", dcnt, 0);
`ifdef NEURON_PROBE_EXPECT_EN
        run_sweep(2'd2, 3'd1, lat);
        chk("s6_pass1", pass, 1);
        tick();
        chk("s6_pass_hold", pass, 1);
        run_sweep(2'd2, 3'd4, lat);
        chk("s6_pass0", pass, 0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/neuron_probe.md
# neuron_probe

Sequential characterizer that sits on the opposite side of a two-input McCulloch-Pitts neuron node. It drives the node's `x`, `y` and `Threshold` inputs, sweeps all four input combinations, and samples `fire` after each settles. It then reports the captured truth table and a decoded logic-function code. It replaces hand-written stimulus sequences with a start/done handshake usable by higher-level control or self-test logic.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles each input combination is held before `fire` is sampled; legal range ≥1.
- `THRESH_W`, default 2: width of the threshold bus.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `start`  in  1  request a sweep; accepted only in IDLE.
- `thresh_cfg`  in  THRESH_W  threshold to apply; latched when `start` is accepted.
- `x`  out  1  neuron input x.
- `y`  out  1  neuron input y.
- `Threshold`  out  THRESH_W  neuron threshold.
- `fire`  in  1  neuron output being probed.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  single-cycle pulse when results are valid.
- `truth`  out  4  captured table; bit index = {x,y}.
- `func_code`  out  3  decoded function (see Operation).
- `error`  out  1  captured table is non-monotonic.
- `expect_code`  in  3  present only with `NEURON_PROBE_EXPECT_EN`.
- `pass`  out  1  present only with `NEURON_PROBE_EXPECT_EN`.

## Operation
- States: IDLE → SWEEP → DONE → IDLE.
- IDLE:
  - `x`=`y`=0 and `busy`=0.
  - `Threshold` holds its last value.
  - `start`=1 latches `thresh_cfg` into `Threshold`, clears the index counter `idx` and the settle counter, and moves to SWEEP.
- SWEEP:
  - `{x,y}`=`idx`.
  - The settle counter counts 0..SETTLE_CYCLES-1.
  - On the edge ending the last settle cycle, `fire` is written into `truth[idx]`, `idx` increments, and the settle counter clears.
  - After `idx`=3 is sampled, the state moves to DONE.
  - `truth` is cleared to 0 when the sweep starts.
- DONE:
  - `done`=1 for one cycle; `func_code` and `error` are updated from `truth` in the same cycle.
  - The state returns to IDLE.
- Decode of `truth`:
  - 0000 → 0 CONST0
  - 1000 → 1 AND
  - 1100 → 2 FOLLOW_X
  - 1010 → 3 FOLLOW_Y
  - 1110 → 4 OR
  - 1111 → 5 CONST1
  - any other value → 7 INVALID with `error`=1.
- Results (`truth`, `func_code`, `error`) hold until the next accepted `start`. At that start `func_code` and `error` keep their old values until the next DONE; only `truth` clears.
- `start` in SWEEP or DONE is ignored and not queued.
- `thresh_cfg` changes after acceptance have no effect on the sweep in progress.

## Timing
- `start` accepted at cycle T:
  - `busy`=1 in cycles T+1 .. T+4·SETTLE_CYCLES.
  - `done` pulses at T+1+4·SETTLE_CYCLES.
  - Example: SETTLE_CYCLES=2 gives `done` at T+9.
- `fire` is sampled SETTLE_CYCLES cycles after the corresponding `{x,y}` is first driven. A combinational neuron is therefore always stable.
- Reset values: `x`=0, `y`=0, `Threshold`=0, `busy`=0, `done`=0, `truth`=0, `func_code`=0, `error`=0, `pass`=0; state IDLE.
- Reset asserted mid-sweep aborts the sweep immediately, applies the reset values above, and produces no `done`.

## Configuration
- `NEURON_PROBE_EXPECT_EN` defined:
  - Adds `expect_code` (latched with `thresh_cfg` at start) and `pass`.
  - `pass` is updated in the DONE cycle: 1 iff `func_code`==`expect_code` and `error`=0. It holds until the next DONE or reset.
- Not defined: neither port exists, and behaviour is otherwise identical.

## Test plan
For scenarios 1–4 and 6, the bench drives `fire` from a behavioural neuron (`fire` = (x+y ≥ Threshold)) with SETTLE_CYCLES=2.
1. `thresh_cfg`=2, `start` pulse → `truth`=1000, `func_code`=1, `error`=0, `done` exactly 9 cycles after `start`; `x`/`y` step 00,01,10,11 every 2 cycles.
2. `thresh_cfg`=1 → `truth`=1110, `func_code`=4.
3. `thresh_cfg`=0, then a second sweep with `thresh_cfg`=3 → 1111/code 5, then 0000/code 0; `Threshold` output holds 3 in IDLE afterwards.
4. `start` re-pulsed during SWEEP and during the DONE cycle → ignored; exactly one `done`, and the result matches the first request.
5. Bench drives `fire` = x XOR y → `truth`=0110, `func_code`=7, `error`=1.
6. `rst_n` low for one cycle while `idx`=2 → all outputs 0 on the next cycle and no `done`. With `NEURON_PROBE_EXPECT_EN`, a following sweep with `expect_code`=1 and `thresh_cfg`=2 → `pass`=1; with `expect_code`=4 → `pass`=0.
